// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID-stage instruction info and branch/stall inputs in,
// forwarding selects, CSR-writer flags, pipeline control and statistics out.
interface hazard_ctrl_if;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [4:0]  id_rd;
   logic        id_reg_wen;
   logic        id_is_load;
   logic        id_csr_en;
   logic        ex_branch_taken;
   logic        ext_stall;
   logic [1:0]  forwardA;
   logic [1:0]  forwardB;
   logic        MEM_csr_reg_en;
   logic        WB_csr_reg_en;
   logic        pc_stall;
   logic        id_stall;
   logic        id_flush;
   logic        ex_bubble;
   logic [31:0] stall_count;
   logic [31:0] flush_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_wen,
             id_is_load, id_csr_en, ex_branch_taken, ext_stall,
      input  forwardA, forwardB, MEM_csr_reg_en, WB_csr_reg_en,
             pc_stall, id_stall, id_flush, ex_bubble, stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_wen,
             id_is_load, id_csr_en, ex_branch_taken, ext_stall,
      output forwardA, forwardB, MEM_csr_reg_en, WB_csr_reg_en,
             pc_stall, id_stall, id_flush, ex_bubble, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM/WB destination scoreboard, operand forwarding,
// load-use stall and branch flush. Define HAZARD_CTRL_STATS_EN for stall/flush counters.
module hazard_ctrl (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hif
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
      logic       load;
      logic       csr;
   } sb_entry_t;

   sb_entry_t  ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_entry_s;
   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic       mem_csr_q, mem_csr_d, wb_csr_q, wb_csr_d;
   logic       load_use_s;
   logic       pc_stall_s, id_stall_s, id_flush_s, ex_bubble_s;

   function automatic logic is_producer(input sb_entry_t e, input logic [4:0] r);
      return e.valid & e.wen & (e.rd != 5'd0) & (e.rd == r);
   endfunction

   // The EX entry will sit in MEM when the ID instruction reaches EX, hence 10.
   function automatic logic [1:0] fwd_sel(input logic use_flag, input logic [4:0] r,
                                          input sb_entry_t ex_e, input sb_entry_t mem_e);
      logic [1:0] sel;
      if (!use_flag) begin
         sel = 2'b00;
      end else if (is_producer(ex_e, r)) begin
         sel = 2'b10;
      end else if (is_producer(mem_e, r)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   always_comb begin
      id_entry_s = '{valid: hif.id_valid, rd: hif.id_rd, wen: hif.id_reg_wen,
                     load: hif.id_is_load, csr: hif.id_csr_en};
      load_use_s = hif.id_valid & ex_q.load &
                   ((hif.id_use_rs1 & is_producer(ex_q, hif.id_rs1)) |
                    (hif.id_use_rs2 & is_producer(ex_q, hif.id_rs2)));
      pc_stall_s  = 1'b0;
      id_stall_s  = 1'b0;
      id_flush_s  = 1'b0;
      ex_bubble_s = 1'b0;
      ex_d        = ex_q;
      mem_d       = mem_q;
      wb_d        = wb_q;
      fwd_a_d     = fwd_a_q;
      fwd_b_d     = fwd_b_q;
      if (hif.ext_stall) begin
         pc_stall_s = 1'b1;
         id_stall_s = 1'b1;
      end else begin
         wb_d  = mem_q;
         mem_d = ex_q;
         // A taken branch discards the ID instruction, so it also masks load-use.
         if (hif.ex_branch_taken) begin
            id_flush_s  = 1'b1;
            ex_bubble_s = 1'b1;
         end else if (load_use_s) begin
            pc_stall_s  = 1'b1;
            id_stall_s  = 1'b1;
            ex_bubble_s = 1'b1;
         end else begin
            ex_bubble_s = 1'b0;
         end
         if (ex_bubble_s) begin
            ex_d    = '0;
            fwd_a_d = 2'b00;
            fwd_b_d = 2'b00;
         end else begin
            ex_d    = id_entry_s;
            fwd_a_d = fwd_sel(hif.id_use_rs1, hif.id_rs1, ex_q, mem_q);
            fwd_b_d = fwd_sel(hif.id_use_rs2, hif.id_rs2, ex_q, mem_q);
         end
      end
      mem_csr_d = mem_d.valid & mem_d.csr;
      wb_csr_d  = wb_d.valid & wb_d.csr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         fwd_a_q   <= 2'b00;
         fwd_b_q   <= 2'b00;
         mem_csr_q <= 1'b0;
         wb_csr_q  <= 1'b0;
      end else begin
         ex_q      <= ex_d;
         mem_q     <= mem_d;
         wb_q      <= wb_d;
         fwd_a_q   <= fwd_a_d;
         fwd_b_q   <= fwd_b_d;
         mem_csr_q <= mem_csr_d;
         wb_csr_q  <= wb_csr_d;
      end
   end

   assign hif.forwardA       = fwd_a_q;
   assign hif.forwardB       = fwd_b_q;
   assign hif.MEM_csr_reg_en = mem_csr_q;
   assign hif.WB_csr_reg_en  = wb_csr_q;
   assign hif.pc_stall       = pc_stall_s;
   assign hif.id_stall       = id_stall_s;
   assign hif.id_flush       = id_flush_s;
   assign hif.ex_bubble      = ex_bubble_s;

`ifdef HAZARD_CTRL_STATS_EN
   logic [31:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

   // Counters wrap naturally; frozen cycles never count.
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (!hif.ext_stall && !hif.ex_branch_taken && load_use_s) begin
         stall_count_d = stall_count_q + 32'd1;
      end else begin
         stall_count_d = stall_count_q;
      end
      if (!hif.ext_stall && hif.ex_branch_taken) begin
         flush_count_d = flush_count_q + 32'd1;
      end else begin
         flush_count_d = flush_count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= 32'd0;
         flush_count_q <= 32'd0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign hif.stall_count = stall_count_q;
   assign hif.flush_count = flush_count_q;
`else
   assign hif.stall_count = 32'd0;
   assign hif.flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected output vectors are queued
// with the stimulus and popped at each falling edge for comparison.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   hazard_ctrl_if hif ();

   hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hif(hif));

   always #5 clk = ~clk;

`ifdef HAZARD_CTRL_STATS_EN
   localparam logic STATS = 1'b1;
`else
   localparam logic STATS = 1'b0;
`endif

   // {valid, rs1, use1, rs2, use2, rd, wen, load, csr, branch, ext_stall}
   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       wen;
      logic       ld;
      logic       csr;
      logic       br;
      logic       xs;
   } stim_t;

   int n_tests = 0;
   int n_fail  = 0;
   logic [9:0] exp_q[$];

   // flags = {wen, load, csr, branch, ext_stall}
   function automatic stim_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic [4:0] flags);
      stim_t s;
      s = '{v: v, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, wen: flags[4],
            ld: flags[3], csr: flags[2], br: flags[1], xs: flags[0]};
      return s;
   endfunction

   // expected vector = {forwardA, forwardB, {MEM_csr, WB_csr}, {pc_stall, id_stall, id_flush, ex_bubble}}
   function automatic logic [9:0] E(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic [1:0] csr, input logic [3:0] ctl);
      return {fa, fb, csr, ctl};
   endfunction

   function automatic logic [9:0] obs();
      return {hif.forwardA, hif.forwardB, hif.MEM_csr_reg_en, hif.WB_csr_reg_en,
              hif.pc_stall, hif.id_stall, hif.id_flush, hif.ex_bubble};
   endfunction

   task automatic apply(input stim_t s);
      hif.id_valid        = s.v;
      hif.id_rs1          = s.rs1;
      hif.id_use_rs1      = s.u1;
      hif.id_rs2          = s.rs2;
      hif.id_use_rs2      = s.u2;
      hif.id_rd           = s.rd;
      hif.id_reg_wen      = s.wen;
      hif.id_is_load      = s.ld;
      hif.id_csr_en       = s.csr;
      hif.ex_branch_taken = s.br;
      hif.ext_stall       = s.xs;
   endtask

   // Drive one ID cycle just after the rising edge, return at the falling edge.
   task automatic drive(input stim_t s);
      @(posedge clk);
      #1;
      apply(s);
      @(negedge clk);
   endtask

   task automatic do_reset();
      apply('0);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_tests++;
      if (obs() !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b exp=%b", obs(), 10'd0);
      end
      n_tests++;
      if (hif.stall_count !== 32'd0 || hif.flush_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_counts got=%0d/%0d exp=0/0", hif.stall_count, hif.flush_count);
      end
   endtask

   task automatic test_fwd_ex();
      stim_t st[$];
      logic [9:0] e;
      do_reset();
      st.push_back(mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 5'b10000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back(mk(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 5'b10000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back('0);                                               exp_q.push_back(E(2'b10, 2'b00, 2'b00, 4'b0000));
      st.push_back('0);                                               exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      foreach (st[i]) begin
         drive(st[i]);
         e = exp_q.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL fwd_ex cyc%0d got=%b exp=%b", i, obs(), e);
         end
      end
   endtask

   task automatic test_fwd_mem();
      stim_t st[$];
      logic [9:0] e;
      for (int pass = 0; pass < 2; pass++) begin
         logic [4:0] rd;
         rd = (pass == 0) ? 5'd5 : 5'd0;
         do_reset();
         st.delete();
         st.push_back(mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, rd, 5'b10000));   exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
         st.push_back(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'b10000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
         st.push_back(mk(1'b1, 5'd1, 1'b1, rd, 1'b1, 5'd8, 5'b10000));   exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
         st.push_back('0);
         exp_q.push_back(E(2'b00, (pass == 0) ? 2'b01 : 2'b00, 2'b00, 4'b0000));
         foreach (st[i]) begin
            drive(st[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
               n_fail++;
               $display("FAIL fwd_mem pass%0d cyc%0d got=%b exp=%b", pass, i, obs(), e);
            end
         end
      end
   endtask

   task automatic test_load_use();
      stim_t st[$];
      logic [9:0] e;
      do_reset();
      st.push_back(mk(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 5'b11000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back(mk(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 5'b10000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b1101));
      st.push_back(mk(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 5'b10000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back('0);                                               exp_q.push_back(E(2'b01, 2'b00, 2'b00, 4'b0000));
      foreach (st[i]) begin
         drive(st[i]);
         e = exp_q.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL load_use cyc%0d got=%b exp=%b", i, obs(), e);
         end
      end
      n_tests++;
      if (hif.stall_count !== (STATS ? 32'd1 : 32'd0) || hif.flush_count !== 32'd0) begin
         n_fail++;
         $display("FAIL load_use_counts got=%0d/%0d exp=%0d/0", hif.stall_count, hif.flush_count, STATS ? 1 : 0);
      end
   endtask

   task automatic test_branch_vs_load_use();
      stim_t st[$];
      logic [9:0] e;
      do_reset();
      st.push_back(mk(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 5'b11000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back(mk(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 5'b10010)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0011));
      st.push_back('0);                                               exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back('0);                                               exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      foreach (st[i]) begin
         drive(st[i]);
         e = exp_q.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL branch_vs_load_use cyc%0d got=%b exp=%b", i, obs(), e);
         end
      end
      n_tests++;
      if (hif.flush_count !== (STATS ? 32'd1 : 32'd0) || hif.stall_count !== 32'd0) begin
         n_fail++;
         $display("FAIL branch_counts got=%0d/%0d exp=0/%0d", hif.stall_count, hif.flush_count, STATS ? 1 : 0);
      end
   endtask

   task automatic test_csr();
      stim_t st[$];
      logic [9:0] e;
      do_reset();
      st.push_back(mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 5'b10100)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back(mk(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 5'b10000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back('0);                                               exp_q.push_back(E(2'b10, 2'b00, 2'b10, 4'b0000));
      st.push_back('0);                                               exp_q.push_back(E(2'b00, 2'b00, 2'b01, 4'b0000));
      st.push_back('0);                                               exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      foreach (st[i]) begin
         drive(st[i]);
         e = exp_q.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL csr cyc%0d got=%b exp=%b", i, obs(), e);
         end
      end
   endtask

   task automatic test_ext_stall_reset();
      stim_t st[$];
      logic [9:0] e;
      do_reset();
      // csrrw x3; lw x7 <- x3; then add reading x7 while memory is busy
      st.push_back(mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 5'b10100)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back(mk(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 5'b11000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      for (int k = 0; k < 3; k++) begin
         st.push_back(mk(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 5'b10001));
         exp_q.push_back(E(2'b10, 2'b00, 2'b10, 4'b1100));
      end
      foreach (st[i]) begin
         drive(st[i]);
         e = exp_q.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL ext_stall cyc%0d got=%b exp=%b", i, obs(), e);
         end
      end
      n_tests++;
      if (hif.stall_count !== 32'd0) begin
         n_fail++;
         $display("FAIL ext_stall_no_count got=%0d exp=0", hif.stall_count);
      end
      #2;
      rst_n = 1'b0;
      apply('0);
      #1;
      n_tests++;
      if (obs() !== 10'd0 || hif.stall_count !== 32'd0 || hif.flush_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_stall got=%b cnt=%0d/%0d exp=0", obs(), hif.stall_count, hif.flush_count);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      // Empty scoreboard: reading x7 must not stall; first advance is normal.
      st.delete();
      st.push_back(mk(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd9, 5'b10000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back(mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 5'b10000)); exp_q.push_back(E(2'b00, 2'b00, 2'b00, 4'b0000));
      st.push_back('0);                                               exp_q.push_back(E(2'b10, 2'b00, 2'b00, 4'b0000));
      foreach (st[i]) begin
         drive(st[i]);
         e = exp_q.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL post_reset cyc%0d got=%b exp=%b", i, obs(), e);
         end
      end
   endtask

   initial begin
      apply('0);
      test_reset();
      test_fwd_ex();
      test_fwd_mem();
      test_load_use();
      test_branch_vs_load_use();
      test_csr();
      test_ext_stall_reset();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have clk, input, 1: rising-edge clock for all state.
REQ-002 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have id_valid, input, 1: a valid instruction is in ID.
REQ-004 SHALL have id_rs1 and id_rs2, inputs, 5 each: ID source registers.
REQ-005 SHALL have id_use_rs1 and id_use_rs2, inputs, 1 each: the ALU A/B operand reads the register. It is low when ASel/BSel picks PC/imm.
REQ-006 SHALL have id_rd, input, 5, and id_reg_wen, input, 1: ID destination register and its write enable.
REQ-007 SHALL have id_is_load and id_csr_en, inputs, 1 each: ID instruction is a load, or a CSR read-to-register.
REQ-008 SHALL have ex_branch_taken, input, 1: the EX instruction redirects the PC.
REQ-009 SHALL have ext_stall, input, 1: memory busy; freeze the whole pipeline.
REQ-010 SHALL have forwardA and forwardB, outputs, 2 each: ALU operand select for the instruction in EX. Encoding: 00 none, 10 MEM, 01 WB.
REQ-011 SHALL have MEM_csr_reg_en and WB_csr_reg_en, outputs, 1 each: the MEM/WB entry is a valid CSR writer.
REQ-012 SHALL have pc_stall, id_stall, id_flush and ex_bubble, outputs, 1 each: pipeline control.
REQ-013 SHALL have stall_count and flush_count, outputs, 32 each: statistics (see Configuration).

Function
REQ-014 SHALL keep a three-entry scoreboard (EX, MEM, WB). Each entry holds {valid, rd, wen, load, csr}.
REQ-015 Normal advance SHALL apply on each clk edge: ID→EX, EX→MEM, MEM→WB; the WB entry retires.
REQ-016 An entry SHALL be a producer for register r only when valid & wen & rd!=0 & rd==r; x0 SHALL never forward.
REQ-017 Forward select for each operand SHALL be computed in ID and registered into EX, giving a 1-cycle latency:
- EX-entry producer → 10
- else MEM-entry producer → 01
- else 00
- the operand's use flag low → 00
REQ-018 Load-use: when the EX entry is a load producer for a used ID source and id_valid=1:
- assert pc_stall=id_stall=ex_bubble=1 for exactly one cycle
- EX receives an invalid entry with forwardA=forwardB=00
- ID is held
- on the next cycle the held instruction gets forward 01 from the load, now in MEM
REQ-019 Branch: ex_branch_taken=1 SHALL assert id_flush=ex_bubble=1. EX receives an invalid entry and no stall is raised. Branch SHALL beat load-use in the same cycle.
REQ-020 ext_stall=1 SHALL hold all entries and forward registers and assert pc_stall=id_stall=1. Flush and load-use are ignored that cycle; the requester holds its input until the stall clears.
REQ-021 MEM_csr_reg_en and WB_csr_reg_en SHALL equal valid & csr of the MEM and WB entries (registered).
REQ-022 Stall/flush outputs SHALL be combinational from the current inputs and scoreboard. All other outputs SHALL be registered.

Reset
REQ-023 rst_n low SHALL immediately invalidate all entries and force forwardA, forwardB, the CSR enables and both counters to 0.
REQ-024 Reset SHALL win over every concurrent event, including mid-stall and mid-flush. The first edge after release SHALL perform a normal advance.

Configuration
REQ-025 With HAZARD_CTRL_STATS_EN defined:
- stall_count increments on each load-use stall cycle
- flush_count increments on each branch flush
- both wrap at 2^32 and do not count during ext_stall
REQ-026 Without HAZARD_CTRL_STATS_EN: both ports SHALL be driven constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-027 add x5 then add reading x5 as rs1, back-to-back → forwardA=10 and forwardB=00 in the second add's EX cycle.
REQ-028 add x5, nop, sub reading x5 on rs2 → forwardB=01. The same sequence with rd=x0 → forwardB=00.
REQ-029 lw x7 then add reading x7 as rs1 → one cycle of pc_stall=id_stall=ex_bubble=1, then forwardA=01; stall_count=1 with the macro, 0 without.
REQ-030 Load-use and ex_branch_taken=1 in the same cycle → id_flush=1 and pc_stall=0; flush_count=1 with the macro, stall_count=0.
REQ-031 csrrw to x3 followed by an instruction reading x3 → forwardA=10, then MEM_csr_reg_en=1 and, one cycle later, WB_csr_reg_en=1.
REQ-032 ext_stall high for 3 cycles during a load-use stall, then rst_n pulsed low → outputs frozen during the stall; after reset all outputs are 0 and the scoreboard is empty.
